// File: rtl/eth_rx_fcs_check_pkg.sv
// Shared FCS constants and beat type for the Ethernet CRC32 path.
// The TX FCS inserter uses the same polynomial, init value and FCS length.
package eth_rx_fcs_check_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Register value left after running the CRC over payload plus a correct FCS
  // (reflected form, no final inversion).
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_LEN       = 4;
  localparam int          CNT_W         = $clog2(FCS_LEN + 1);

  typedef logic [CNT_W-1:0] fcs_cnt_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } axis_beat_t;

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// AXI-stream byte bus used on both sides of the RX FCS checker.
//   tdata  : byte, frame order
//   tvalid : beat valid
//   tready : beat accepted with tvalid
//   tlast  : last beat of frame
//   tuser  : error flag (meaning depends on the side)
interface eth_rx_fcs_check_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/lfsr.sv
// Combinational single-step LFSR / CRC engine.
// Advances state_in by DATA_WIDTH input bits and presents the result on
// state_out. With REVERSE=1 data and state are bit-reflected, which gives the
// LSB-first CRC used by Ethernet.
//   data_in   : DATA_WIDTH bits fed in this step
//   state_in  : current LFSR state
//   state_out : state after consuming data_in
module lfsr #(
  parameter int                    LFSR_WIDTH        = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 32'h04c11db7,
  parameter string                 LFSR_CONFIG       = "GALOIS",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b1,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] d;
    logic                  fb;
    s  = '0;
    d  = '0;
    fb = 1'b0;
    for (int i = 0; i < LFSR_WIDTH; i++) s[i] = REVERSE ? state_in[LFSR_WIDTH-1-i] : state_in[i];
    for (int i = 0; i < DATA_WIDTH; i++) d[i] = REVERSE ? data_in[DATA_WIDTH-1-i] : data_in[i];
    // MSB-first stepping; after reflection the MSB of d is data_in[0].
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (IS_GALOIS) begin
        // Feed-forward injects data after the tap XOR instead of into feedback.
        fb = s[LFSR_WIDTH-1] ^ (LFSR_FEED_FORWARD ? 1'b0 : d[i]);
        s  = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? d[i] : 1'b0)} ^ (fb ? LFSR_POLY : '0);
      end else begin
        fb = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
        s  = {s[LFSR_WIDTH-2:0], fb ^ d[i]};
      end
    end
    for (int i = 0; i < LFSR_WIDTH; i++) state_out[i] = REVERSE ? s[LFSR_WIDTH-1-i] : s[i];
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX FCS checker. Runs CRC32 over every received byte (FCS included),
// strips the trailing 4 FCS bytes and marks a bad frame on the last forwarded
// beat. Frames of 4 bytes or fewer are dropped as runts.
//   clk, rst        : clock, synchronous active-high reset
//   s_axis          : input frame stream, FCS last, tuser = PHY rx_er per beat
//   m_axis          : payload stream, tuser on tlast = frame bad
//   stat_fcs_bad    : pulse, frame ended with CRC mismatch
//   stat_frame_good : pulse, frame ended with CRC match
//   stat_runt       : pulse, runt frame dropped
module eth_rx_fcs_check
  import eth_rx_fcs_check_pkg::*;
#(
  parameter bit ENABLE_STATS = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  eth_rx_fcs_check_if.slave         s_axis,
  eth_rx_fcs_check_if.master        m_axis,
  output logic                      stat_fcs_bad,
  output logic                      stat_frame_good,
  output logic                      stat_runt
);

  logic [31:0]               crc_state;
  logic [31:0]               crc_next;
  logic [FCS_LEN-1:0][7:0]   fcs_buf;
  fcs_cnt_t                  cnt;
  logic                      err_flag;
  axis_beat_t                out_beat;
  logic                      out_vld;
  logic                      accept;
  logic                      eof;
  logic                      full;
  logic                      crc_bad;
  logic                      fcs_bad_q;
  logic                      good_q;
  logic                      runt_q;

  // Single register slice: take a byte whenever the output slot is free or
  // being drained this cycle.
  assign s_axis.tready = !rst && (!out_vld || m_axis.tready);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign eof           = accept && s_axis.tlast;
  assign full          = (cnt == fcs_cnt_t'(FCS_LEN));
  assign crc_bad       = (crc_next != CRC32_RESIDUE);

  lfsr #(
    .LFSR_WIDTH       (32),
    .LFSR_POLY        (CRC32_POLY),
    .LFSR_CONFIG      ("GALOIS"),
    .LFSR_FEED_FORWARD(1'b0),
    .REVERSE          (1'b1),
    .DATA_WIDTH       (8)
  ) u_crc (
    .data_in  (s_axis.tdata),
    .state_in (crc_state),
    .state_out(crc_next)
  );

  // The last FCS_LEN bytes are always held back; a byte is only known to be
  // payload once FCS_LEN newer bytes have arrived behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      crc_state <= CRC32_INIT;
      err_flag  <= 1'b0;
      fcs_buf   <= '0;
    end else if (accept) begin
      fcs_buf <= {fcs_buf[FCS_LEN-2:0], s_axis.tdata};
      if (eof) begin
        cnt       <= '0;
        crc_state <= CRC32_INIT;
        err_flag  <= 1'b0;
      end else begin
        crc_state <= crc_next;
        err_flag  <= err_flag || s_axis.tuser;
        if (!full) cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_beat <= '0;
    end else begin
      if (out_vld && m_axis.tready) out_vld <= 1'b0;
      if (accept && full) begin
        out_vld       <= 1'b1;
        out_beat.data <= fcs_buf[FCS_LEN-1];
        out_beat.last <= s_axis.tlast;
        out_beat.user <= s_axis.tlast && (crc_bad || err_flag || s_axis.tuser);
      end
    end
  end

  // Stats follow the CRC result only; rx_er does not move a frame to bad.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcs_bad_q <= 1'b0;
      good_q    <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      fcs_bad_q <= eof && full && crc_bad;
      good_q    <= eof && full && !crc_bad;
      runt_q    <= eof && !full;
    end
  end

  assign stat_fcs_bad    = ENABLE_STATS && fcs_bad_q;
  assign stat_frame_good = ENABLE_STATS && good_q;
  assign stat_runt       = ENABLE_STATS && runt_q;

  assign m_axis.tvalid = out_vld;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tuser  = out_beat.user;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
module tb_eth_rx_fcs_check;

  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_fcs_check_if s_if ();
  eth_rx_fcs_check_if m_if ();
  logic stat_fcs_bad, stat_frame_good, stat_runt;

  eth_rx_fcs_check #(.ENABLE_STATS(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .stat_fcs_bad   (stat_fcs_bad),
    .stat_frame_good(stat_frame_good),
    .stat_runt      (stat_runt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t out_q[$];
  beat_t exp_q[$];
  int    n_good = 0, n_bad = 0, n_runt = 0;
  int    e_good = 0, e_bad = 0, e_runt = 0;
  int    vld_seen = 0;
  int    first_vld = -1;
  int    acc_cyc[$];
  int    bp_mode = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC32 (IEEE 802.3, reflected, final inversion) of a byte list.
  function automatic logic [31:0] crc32(input byte_q_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    logic [31:0] f = crc32(p);
    byte_q_t r = p;
    for (int k = 0; k < 4; k++) r.push_back(f[8*k +: 8]);
    return r;
  endfunction

  function automatic bit_q_t zeros(input int n);
    bit_q_t r;
    for (int i = 0; i < n; i++) r.push_back(1'b0);
    return r;
  endfunction

  // Expected payload: all but the last 4 bytes; bad when the transmitted FCS
  // disagrees with the CRC of the payload or any byte carried rx_er.
  function automatic void model(input byte_q_t b, input bit_q_t u);
    int n = b.size();
    byte_q_t p;
    logic [31:0] fcs_rx;
    bit ok, anyu;
    if (n <= 4) begin
      e_runt++;
      return;
    end
    for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
    fcs_rx = {b[n-1], b[n-2], b[n-3], b[n-4]};
    ok = (crc32(p) == fcs_rx);
    anyu = 1'b0;
    foreach (u[i]) anyu |= u[i];
    for (int i = 0; i < n - 4; i++)
      exp_q.push_back('{d: p[i], l: (i == n - 5), u: (i == n - 5) && (!ok || anyu)});
    if (ok) e_good++; else e_bad++;
  endfunction

  task automatic monitor();
    bit stall_p = 1'b0;
    logic [10:0] st = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("s_tready_rule", s_if.tready, !(m_if.tvalid && !m_if.tready));
        if (stall_p)
          chk("stall_stable", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, st);
        stall_p = m_if.tvalid && !m_if.tready;
        st = {1'b1, m_if.tdata, m_if.tlast, m_if.tuser};
        if (m_if.tvalid) begin
          vld_seen++;
          if (first_vld < 0) first_vld = cyc;
        end
        if (m_if.tvalid && m_if.tready) out_q.push_back('{m_if.tdata, m_if.tlast, m_if.tuser});
        n_good += int'(stat_frame_good);
        n_bad  += int'(stat_fcs_bad);
        n_runt += int'(stat_runt);
      end else begin
        stall_p = 1'b0;
      end
    end
  endtask

  task automatic bp_drive();
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send_frame(input byte_q_t b, input bit_q_t u, input bit with_last);
    bit ok;
    int n;
    for (int i = 0; i < b.size(); i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = b[i];
      s_if.tlast  = with_last && (i == b.size() - 1);
      s_if.tuser  = u[i];
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        ok = s_if.tready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!ok) chk("accept_timeout", ok, 1'b1);
      acc_cyc.push_back(cyc);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n = 0;
    while (out_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    chk({tag, "_good"}, n_good, e_good);
    chk({tag, "_bad"}, n_bad, e_bad);
    chk({tag, "_runt"}, n_runt, e_runt);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    byte_q_t f1, f2, p;
    bit_q_t  u1;
    int      len;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    fork
      monitor();
      bp_drive();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_axis", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, '0);
    chk("rst_stats", {stat_fcs_bad, stat_frame_good, stat_runt}, '0);
    chk("rst_s_tready", s_if.tready, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Known-answer good frame "123456789" + FCS 26 39 F4 CB
    f1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    first_vld = -1;
    acc_cyc.delete();
    model(f1, zeros(13));
    send_frame(f1, zeros(13), 1'b1);
    chk("latency_first_byte", first_vld, acc_cyc[4]);
    check_all("good_kat");

    // Same frame, 5th byte corrupted
    f2 = f1;
    f2[4] = 8'h34;
    model(f2, zeros(13));
    send_frame(f2, zeros(13), 1'b1);
    check_all("corrupt");

    // Runt, then a clean good frame
    vld_seen = 0;
    f2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model(f2, zeros(4));
    send_frame(f2, zeros(4), 1'b1);
    check_all("runt");
    chk("runt_no_valid", vld_seen, 0);
    model(f1, zeros(13));
    send_frame(f1, zeros(13), 1'b1);
    check_all("after_runt");

    // Backpressure
    bp_mode = 1;
    p.delete();
    for (int i = 0; i < 20; i++) p.push_back(8'($urandom));
    f2 = with_fcs(p);
    model(f2, zeros(f2.size()));
    send_frame(f2, zeros(f2.size()), 1'b1);
    check_all("backpressure");
    bp_mode = 0;

    // rx_er on byte 3, then a clean frame back-to-back
    u1 = zeros(13);
    u1[2] = 1'b1;
    model(f1, u1);
    model(f1, zeros(13));
    send_frame(f1, u1, 1'b1);
    send_frame(f1, zeros(13), 1'b1);
    check_all("rxer_b2b");

    // Reset mid-frame after 6 bytes
    send_frame(f1[0:5], zeros(6), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_m_axis", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, '0);
    chk("midrst_stats", {stat_fcs_bad, stat_frame_good, stat_runt}, '0);
    chk("midrst_s_tready", s_if.tready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_q.delete();
    model(f1, zeros(13));
    send_frame(f1, zeros(13), 1'b1);
    check_all("after_midrst");

    // Randomised back-to-back frames: good, corrupt, rx_er, runts, backpressure
    bp_mode = 1;
    for (int k = 0; k < 12; k++) begin
      p.delete();
      if ($urandom_range(0, 4) == 0) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        f2 = p;
      end else begin
        len = $urandom_range(1, 24);
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        f2 = with_fcs(p);
        if ($urandom_range(0, 2) == 0) begin
          len = $urandom_range(0, f2.size() - 1);
          f2[len] = f2[len] ^ (8'h1 << $urandom_range(0, 7));
        end
      end
      u1 = zeros(f2.size());
      foreach (u1[i]) u1[i] = ($urandom_range(0, 15) == 0);
      model(f2, u1);
      send_frame(f2, u1, 1'b1);
    end
    check_all("random");
    bp_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
